// File: rtl/fun_sweep_ctrl.sv
// fun_sweep_ctrl: built-in self-test sequencer for the 3-input/2-output `fun` block.
//
// On an accepted start it walks {a,b,c} through all eight vectors. Each vector is held
// for SETTLE+1 cycles, and d/e are sampled on the last edge of that hold window. The
// samples are compared against the golden truth table and accumulated into the
// result registers.
//
// Parameters
//   SETTLE       cycles a vector is held before sampling (legal range 1..15)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start_i      request a sweep (accepted only when idle)
//   abort_i      cancel the sweep in progress (effective only while busy)
//   d_in_i       d output of the fun instance under test
//   e_in_i       e output of the fun instance under test
//   a_o/b_o/c_o  vector driven into fun; {a,b,c} equals the current vector index
//   busy_o       sweep in progress
//   done_o       one-cycle pulse when a sweep completes (not pulsed on abort)
//   pass_o       last completed sweep had zero mismatches
//   err_cnt_o    number of failing vectors (0..8)
//   fail_valid_o at least one mismatch seen in the current or last sweep
//   fail_idx_o   index of the first failing vector
//   d_sig_o      bit i holds the d_in sampled for vector i
//   e_sig_o      bit i holds the e_in sampled for vector i
module fun_sweep_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       d_in_i,
  input  logic       e_in_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [3:0] err_cnt_o,
  output logic       fail_valid_o,
  output logic [2:0] fail_idx_o,
  output logic [7:0] d_sig_o,
  output logic [7:0] e_sig_o
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_settle_range
    $error("fun_sweep_ctrl: SETTLE must be in 1..15");
  end

  // Golden responses, bit i for {a,b,c} = i.
  //   d = ~(a|b) | (b&c)
  //   e = (b&c) ^ c
  localparam logic [7:0] DExp    = 8'h8B;
  localparam logic [7:0] EExp    = 8'h22;
  localparam logic [3:0] CntLoad = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic       fail_valid_q, fail_valid_d;
  logic [2:0] fail_idx_q, fail_idx_d;
  logic       pass_q, pass_d;
  logic [7:0] d_sig_q, d_sig_d;
  logic [7:0] e_sig_q, e_sig_d;
  logic       mismatch;

  // A vector counts once, even if both d and e disagree with the golden table.
  assign mismatch = (d_in_i != DExp[idx_q]) || (e_in_i != EExp[idx_q]);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_idx_d   = fail_idx_q;
    pass_d       = pass_q;
    d_sig_d      = d_sig_q;
    e_sig_d      = e_sig_q;

    unique case (state_q)
      StIdle: begin
        // A start beats a simultaneous abort here, since abort only acts while busy.
        if (start_i) begin
          state_d      = StSettle;
          idx_d        = 3'd0;
          cnt_d        = CntLoad;
          err_cnt_d    = 4'd0;
          fail_valid_d = 1'b0;
          fail_idx_d   = 3'd0;
          pass_d       = 1'b0;
          d_sig_d      = 8'h00;
          e_sig_d      = 8'h00;
        end
      end

      StSettle: begin
        if (abort_i) begin
          state_d = StIdle;
          pass_d  = 1'b0;
        end else if (cnt_q == 4'd0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StSample: begin
        // Abort takes priority over the capture; partial results stay as they were.
        if (abort_i) begin
          state_d = StIdle;
          pass_d  = 1'b0;
        end else begin
          d_sig_d[idx_q] = d_in_i;
          e_sig_d[idx_q] = e_in_i;
          if (mismatch) begin
            err_cnt_d = err_cnt_q + 4'd1;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_idx_d   = idx_q;
            end
          end
          if (idx_q == 3'd7) begin
            state_d = StDone;
            pass_d  = (err_cnt_d == 4'd0);
          end else begin
            state_d = StSettle;
            idx_d   = idx_q + 3'd1;
            cnt_d   = CntLoad;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= 3'd0;
      cnt_q        <= 4'd0;
      err_cnt_q    <= 4'd0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= 3'd0;
      pass_q       <= 1'b0;
      d_sig_q      <= 8'h00;
      e_sig_q      <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
      pass_q       <= pass_d;
      d_sig_q      <= d_sig_d;
      e_sig_q      <= e_sig_d;
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  always_comb begin
    busy_o = (state_q == StSettle) || (state_q == StSample);
    done_o = (state_q == StDone);
    {a_o, b_o, c_o} = busy_o ? idx_q : 3'd0;
  end

  assign pass_o       = pass_q;
  assign err_cnt_o    = err_cnt_q;
  assign fail_valid_o = fail_valid_q;
  assign fail_idx_o   = fail_idx_q;
  assign d_sig_o      = d_sig_q;
  assign e_sig_o      = e_sig_q;

endmodule
